// File: rtl/div_ctrl_pkg.sv
// Shared types and defaults for the divide controller and its divider.
package div_ctrl_pkg;
  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } div_state_t;
endpackage

// File: rtl/div_ctrl_if.sv
// Request/response bundle between a requester (master) and div_ctrl (slave).
interface div_ctrl_if import div_ctrl_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
);
  logic             req_valid;
  logic             req_ready;
  logic             req_signed;
  logic [WIDTH-1:0] req_dividend;
  logic [WIDTH-1:0] req_divisor;
  logic             flush;
  logic             busy;
  logic             resp_valid;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output req_valid, req_signed, req_dividend, req_divisor, flush,
    input  req_ready, busy, resp_valid, hi, lo
  );

  modport slave (
    input  req_valid, req_signed, req_dividend, req_divisor, flush,
    output req_ready, busy, resp_valid, hi, lo
  );
endinterface

// File: rtl/div_ctrl_div.sv
// Sequential restoring divider: loads on the first enabled edge, one quotient
// bit per enabled edge after that, complete after WIDTH+1 enabled edges.
module div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             complete
);
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST = CW'(WIDTH + 1);

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quo, r_rem, r_dsr;
  logic             r_neg_q, r_neg_r;
  logic [WIDTH:0]   w_shift, w_diff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cnt <= '0;
    else if (en && r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
  end

  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dsr};

  // Datapath is deliberately not reset so results survive the count clear.
  always_ff @(posedge clk) begin
    if (en) begin
      if (r_cnt == '0) begin
        r_rem   <= '0;
        r_quo   <= (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
        r_dsr   <= (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
        r_neg_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        r_neg_r <= is_signed & dividend[WIDTH-1];
      end else if (r_cnt != LAST) begin
        if (!w_diff[WIDTH]) begin
          r_rem <= w_diff[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], 1'b1};
        end else begin
          r_rem <= w_shift[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  assign quotient  = r_neg_q ? -r_quo : r_quo;
  assign remainder = r_neg_r ? -r_rem : r_rem;
  assign complete  = (r_cnt == LAST);
endmodule

// File: rtl/div_ctrl.sv
// Divide controller: accepts DIV/DIVU requests, sequences the unsigned divider,
// applies sign fix-up, and handles divide-by-zero and flush.
module div_ctrl import div_ctrl_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic       clk,
  input  logic       reset,
  div_ctrl_if.slave  bus
);
  div_state_t       r_state;
  logic             r_div_en;
  logic             r_neg_q, r_neg_r;
  logic             r_resp_valid;
  logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo;
  logic [WIDTH-1:0] w_quo, w_rem, w_a_mag, w_b_mag;
  logic             w_complete, w_div_rst;

  assign w_a_mag = (bus.req_signed && bus.req_dividend[WIDTH-1]) ? -bus.req_dividend
                                                                  : bus.req_dividend;
  assign w_b_mag = (bus.req_signed && bus.req_divisor[WIDTH-1]) ? -bus.req_divisor
                                                                 : bus.req_divisor;

  // r_div_en is high exactly in RUN, so this holds the count clear outside RUN.
  assign w_div_rst = reset | ~r_div_en;

  div #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (w_div_rst),
    .en        (r_div_en),
    .is_signed (1'b0),
    .dividend  (r_a),
    .divisor   (r_b),
    .quotient  (w_quo),
    .remainder (w_rem),
    .complete  (w_complete)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_div_en     <= 1'b0;
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_hi         <= '0;
      r_lo         <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid && !bus.flush) begin
            r_a     <= w_a_mag;
            r_b     <= w_b_mag;
            r_neg_q <= bus.req_signed & (bus.req_dividend[WIDTH-1] ^ bus.req_divisor[WIDTH-1]);
            r_neg_r <= bus.req_signed & bus.req_dividend[WIDTH-1];
            if (bus.req_divisor == '0) begin
              r_hi         <= bus.req_dividend;
              r_lo         <= '1;
              r_resp_valid <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_div_en <= 1'b1;
              r_state  <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (bus.flush) begin
            r_div_en <= 1'b0;
            r_state  <= S_IDLE;
          end else if (w_complete) begin
            r_div_en <= 1'b0;
            r_state  <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          if (bus.flush) begin
            r_state <= S_IDLE;
          end else begin
            r_lo         <= r_neg_q ? -w_quo : w_quo;
            r_hi         <= r_neg_r ? -w_rem : w_rem;
            r_resp_valid <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.resp_valid = r_resp_valid & ~bus.flush;
  assign bus.hi         = r_hi;
  assign bus.lo         = r_lo;
endmodule

// File: tb/tb_div_ctrl.sv
// Directed and lightly randomised checks of div_ctrl against a reference scoreboard.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  div_ctrl_if #(.WIDTH(32)) bus ();

  div_ctrl #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_signed   = sgn;
    bus.req_dividend = a;
    bus.req_divisor  = b;
  endtask

  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh,
                        input logic [31:0] el, input int elat);
    exp_t e;
    int   n;
    logic busy_ok;
    drive_req(sgn, a, b);
    chk({tag, "_ready"}, bus.req_ready, 1);
    sb.push_back('{hi: eh, lo: el, lat: elat});
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk({tag, "_busy_accept"}, bus.busy, 1);
    n = 0;
    busy_ok = 1'b1;
    while (!bus.resp_valid && n < 100) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_timeout"}, (n < 100), 1);
    e = sb.pop_front();
    chk({tag, "_latency"}, n, e.lat);
    chk({tag, "_busy_thru"}, busy_ok, 1);
    chk({tag, "_lo"}, bus.lo, e.lo);
    chk({tag, "_hi"}, bus.hi, e.hi);
    last_hi = e.hi;
    last_lo = e.lo;
    @(posedge clk); #1;
    chk({tag, "_pulse"}, bus.resp_valid, 0);
    chk({tag, "_idle"}, bus.req_ready, 1);
  endtask

  initial begin
    logic [31:0] a, b, q, r;
    bus.req_valid    = 1'b0;
    bus.req_signed   = 1'b0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    bus.flush        = 1'b0;

    #12;
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_resp", bus.resp_valid, 0);
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_busy", bus.busy, 0);
    @(negedge clk);
    reset = 1'b0;

    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 35);
    run_op("div_m7_2", 1'b1, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 35);
    run_op("div_7_m2", 1'b1, 32'd7, -32'sd2, 32'd1, 32'hFFFF_FFFD, 35);
    run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 35);
    run_op("divu_5_0", 1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 0);
    run_op("divu_big", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 35);

    for (int i = 0; i < 3; i++) begin
      a = $urandom;
      b = $urandom_range(1, 100000);
      run_op("divu_rand", 1'b0, a, b, a % b, a / b, 35);
    end
    for (int i = 0; i < 3; i++) begin
      a = $urandom;
      b = $urandom_range(1, 5000);
      if (i == 1) b = -b;
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      run_op("div_rand", 1'b1, a, b, r, q, 35);
    end

    // Request together with flush in IDLE must not be accepted.
    drive_req(1'b0, 32'd50, 32'd5);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_idle_busy", bus.busy, 0);
    bus.req_valid = 1'b0;
    bus.flush = 1'b0;

    // Flush on the 10th RUN cycle.
    drive_req(1'b0, 32'd1000, 32'd3);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    chk("flush_pre_busy", bus.busy, 1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_busy", bus.busy, 0);
    chk("flush_ready", bus.req_ready, 1);
    chk("flush_hi", bus.hi, last_hi);
    chk("flush_lo", bus.lo, last_lo);
    begin
      int seen;
      seen = 0;
      repeat (40) begin
        @(posedge clk); #1;
        if (bus.resp_valid) seen++;
      end
      chk("flush_no_resp", seen, 0);
    end
    run_op("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 35);

    // Reset pulse between edges in the middle of RUN.
    drive_req(1'b0, 32'd77, 32'd7);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_hi", bus.hi, 0);
    chk("mid_rst_lo", bus.lo, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_resp", bus.resp_valid, 0);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", bus.req_ready, 1);
    run_op("divu_after_rst", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 35);

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
